// File: rtl/crc_xor_engine_pkg.sv
// Shared constants for the XOR-feedback CRC engine:
// FSM state encoding and common generator polynomials.
package crc_xor_engine_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [7:0]  CRC8_POLY        = 8'h07;
   localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

endpackage

// File: rtl/crc_xor_engine_if.sv
// Beat input and result output handshakes of the CRC engine.
// master drives message/consume side, slave is the engine.
interface crc_xor_engine_if #(
   parameter int WIDTH  = 8,
   parameter int DATA_W = 8
);

   logic              START;
   logic              IN_VALID;
   logic              IN_READY;
   logic [DATA_W-1:0] IN_DATA;
   logic              IN_LAST;
   logic              CRC_VALID;
   logic              CRC_READY;
   logic [WIDTH-1:0]  CRC_OUT;
   logic              BUSY;

   modport master (
      output START, IN_VALID, IN_DATA, IN_LAST, CRC_READY,
      input  IN_READY, CRC_VALID, CRC_OUT, BUSY
   );

   modport slave (
      input  START, IN_VALID, IN_DATA, IN_LAST, CRC_READY,
      output IN_READY, CRC_VALID, CRC_OUT, BUSY
   );

endinterface

// File: rtl/crc_xor_step.sv
// One-cycle CRC advance over DATA_W bits, MSB first.
// Pure 2-input XOR network; the techmap target for 74x86 cells.
module crc_xor_step #(
   parameter int               WIDTH  = 8,
   parameter int               DATA_W = 8,
   parameter logic [WIDTH-1:0] POLY   = 8'h07
) (
   input  logic [WIDTH-1:0]  crc,
   input  logic [DATA_W-1:0] data,
   output logic [WIDTH-1:0]  next
);

   logic [WIDTH-1:0] acc;
   logic             fb;

   always_comb begin
      acc = crc;
      fb  = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb  = acc[WIDTH-1] ^ data[i];
         acc = {acc[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb}} & POLY);
      end
      next = acc;
   end

endmodule

// File: rtl/crc_xor_engine.sv
// CRC/LFSR engine: IDLE -> RUN (absorb beats) -> DONE (hold result
// until consumed). START in RUN restarts and blocks that cycle's beat.
module crc_xor_engine
   import crc_xor_engine_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter int               DATA_W = 8,
   parameter logic [WIDTH-1:0] POLY   = CRC8_POLY,
   parameter logic [WIDTH-1:0] INIT   = '0,
   parameter logic [WIDTH-1:0] XOROUT = '0
) (
   input logic            CLK,
   input logic            RST_N,
   crc_xor_engine_if.slave bus
);

   logic [1:0]       state;
   logic [WIDTH-1:0] crc_reg;
   logic [WIDTH-1:0] crc_next;
   logic [WIDTH-1:0] crc_out;
   logic             crc_valid;
   logic             in_ready;
   logic             accept;

   crc_xor_step #(
      .WIDTH  (WIDTH),
      .DATA_W (DATA_W),
      .POLY   (POLY)
   ) u_step (
      .crc  (crc_reg),
      .data (bus.IN_DATA),
      .next (crc_next)
   );

   assign in_ready = (state == ST_RUN) && !bus.START;
   assign accept   = in_ready && bus.IN_VALID;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         crc_reg   <= INIT;
         crc_out   <= '0;
         crc_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.START) begin
                  crc_reg <= INIT;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.START) begin
                  crc_reg <= INIT;
               end else if (accept) begin
                  crc_reg <= crc_next;
                  if (bus.IN_LAST) begin
                     crc_out   <= crc_next ^ XOROUT;
                     crc_valid <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (bus.CRC_READY) begin
                  crc_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.CRC_VALID = crc_valid;
   assign bus.CRC_OUT   = crc_out;
   assign bus.BUSY      = (state != ST_IDLE);

endmodule
